// File: rtl/spwm_modulator_pkg.sv
// Shared constants and types for the three-phase SPWM modulator.
// Table geometry, carrier range and dead-time FSM encodings.
package spwm_modulator_pkg;

    localparam int ADDR_W   = 12;
    localparam int DATA_W   = 7;
    localparam int PHASE_W  = 24;
    localparam int SIN_SIZE = 1 << ADDR_W;

    localparam logic [DATA_W-1:0] CAR_MAX = DATA_W'((1 << DATA_W) - 1);

    typedef enum logic [1:0] {
        DEAD = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2
    } dt_state_t;

endpackage

// File: rtl/spwm_modulator_if.sv
// Sine table bus and gate-driver outputs of the SPWM modulator.
// master = modulator side, slave = table / gate-driver side.
interface spwm_modulator_if;
    import spwm_modulator_pkg::*;

    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] sine_A;
    logic [DATA_W-1:0] sine_B;
    logic [DATA_W-1:0] sine_C;
    logic              gate_AH;
    logic              gate_AL;
    logic              gate_BH;
    logic              gate_BL;
    logic              gate_CH;
    logic              gate_CL;
    logic              sync;

    modport master (
        output address,
        input  sine_A, sine_B, sine_C,
        output gate_AH, gate_AL,
        output gate_BH, gate_BL,
        output gate_CH, gate_CL,
        output sync
    );

    modport slave (
        input  address,
        output sine_A, sine_B, sine_C,
        input  gate_AH, gate_AL,
        input  gate_BH, gate_BL,
        input  gate_CH, gate_CL,
        input  sync
    );

endinterface

// File: rtl/spwm_modulator_deadtime.sv
// One phase leg: raw compare -> complementary gates with dead time.
// Pulses shorter than DT_CYCLES never reach a gate.
module spwm_deadtime
    import spwm_modulator_pkg::*;
#(
    parameter int DT_CYCLES = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic raw,
    output logic gate_h,
    output logic gate_l
);

    localparam int CW = (DT_CYCLES > 1) ? $clog2(DT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DT_CYCLES - 1);

    dt_state_t     state;
    logic [CW-1:0] cnt;
    logic          raw_q;

    // Leg FSM; gates are registered with the state so they never overlap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= DEAD;
            cnt    <= '0;
            raw_q  <= 1'b0;
            gate_h <= 1'b0;
            gate_l <= 1'b0;
        end else begin
            raw_q <= raw;
            if (clr) begin
                state  <= DEAD;
                cnt    <= '0;
                gate_h <= 1'b0;
                gate_l <= 1'b0;
            end else begin
                unique case (state)
                    HI: begin
                        if (!raw) begin
                            state  <= DEAD;
                            cnt    <= '0;
                            gate_h <= 1'b0;
                        end
                    end
                    LO: begin
                        if (raw) begin
                            state  <= DEAD;
                            cnt    <= '0;
                            gate_l <= 1'b0;
                        end
                    end
                    DEAD: begin
                        if (raw != raw_q) begin
                            cnt <= '0;
                        end else if (cnt == LAST) begin
                            cnt    <= '0;
                            state  <= raw ? HI : LO;
                            gate_h <= raw;
                            gate_l <= !raw;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    default: begin
                        state  <= DEAD;
                        cnt    <= '0;
                        gate_h <= 1'b0;
                        gate_l <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/spwm_modulator.sv
// Three-phase SPWM: phase accumulator, triangle carrier, regular
// sampling at the valley, compare and per-phase dead-time legs.
module spwm_modulator
    import spwm_modulator_pkg::*;
#(
    parameter int DT_CYCLES = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [PHASE_W-1:0] freq_word,
    spwm_modulator_if.master   bus
);

    localparam logic [DATA_W-1:0] CAR_TOP = CAR_MAX - DATA_W'(1);

    logic               run;
    logic               dir_up;
    logic [DATA_W-1:0]  carrier;
    logic [PHASE_W-1:0] acc;
    logic [DATA_W-1:0]  samp_a;
    logic [DATA_W-1:0]  samp_b;
    logic [DATA_W-1:0]  samp_c;
    logic               raw_a;
    logic               raw_b;
    logic               raw_c;
    logic               valley;

    assign valley      = run && (carrier == '0);
    assign bus.sync    = valley;
    assign bus.address = acc[PHASE_W-1 -: ADDR_W];

    // Carrier walk, then sample and advance phase once per valley.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run     <= 1'b0;
            dir_up  <= 1'b1;
            carrier <= '0;
            acc     <= '0;
            samp_a  <= '0;
            samp_b  <= '0;
            samp_c  <= '0;
        end else if (!enable) begin
            run     <= 1'b0;
            dir_up  <= 1'b1;
            carrier <= '0;
            acc     <= '0;
        end else begin
            run <= 1'b1;
            if (run) begin
                if (dir_up) begin
                    carrier <= carrier + DATA_W'(1);
                    if (carrier == CAR_TOP) dir_up <= 1'b0;
                end else begin
                    carrier <= carrier - DATA_W'(1);
                    if (carrier == DATA_W'(1)) dir_up <= 1'b1;
                end
            end
            if (valley) begin
                samp_a <= bus.sine_A;
                samp_b <= bus.sine_B;
                samp_c <= bus.sine_C;
                acc    <= acc + freq_word;
            end
        end
    end

    // Registered sample-versus-carrier compare for each phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw_a <= 1'b0;
            raw_b <= 1'b0;
            raw_c <= 1'b0;
        end else begin
            raw_a <= (samp_a > carrier);
            raw_b <= (samp_b > carrier);
            raw_c <= (samp_c > carrier);
        end
    end

    logic ah, al, bh, bl, ch, cl;

    spwm_deadtime #(.DT_CYCLES(DT_CYCLES)) u_dt_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (!enable),
        .raw    (raw_a),
        .gate_h (ah),
        .gate_l (al)
    );

    spwm_deadtime #(.DT_CYCLES(DT_CYCLES)) u_dt_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (!enable),
        .raw    (raw_b),
        .gate_h (bh),
        .gate_l (bl)
    );

    spwm_deadtime #(.DT_CYCLES(DT_CYCLES)) u_dt_c (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (!enable),
        .raw    (raw_c),
        .gate_h (ch),
        .gate_l (cl)
    );

    assign bus.gate_AH = ah;
    assign bus.gate_AL = al;
    assign bus.gate_BH = bh;
    assign bus.gate_BL = bl;
    assign bus.gate_CH = ch;
    assign bus.gate_CL = cl;

endmodule

// File: tb/tb_spwm_modulator.sv
// Directed bench for spwm_modulator: reset, duty, address stepping,
// short-pulse swallowing, enable gating, zero sample.
module tb_spwm_modulator;
    import spwm_modulator_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               enable;
    logic [PHASE_W-1:0] freq_word;

    int n_tests = 0;
    int n_fail  = 0;

    spwm_modulator_if bus ();

    spwm_modulator #(.DT_CYCLES(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .freq_word (freq_word),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] gates();
        return {bus.gate_AH, bus.gate_AL, bus.gate_BH,
                bus.gate_BL, bus.gate_CH, bus.gate_CL};
    endfunction

    task automatic expect_sync(input string tag, input int exp);
        bit ok = 0;
        logic [ADDR_W-1:0] a = '0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.sync) begin
                ok = 1;
                a = bus.address;
                break;
            end
        end
        chk({tag, "_seen"}, 32'(ok), 1);
        chk(tag, 32'(a), exp);
    endtask

    int ah, al, bh, bl, ch, cl, both;

    task automatic window();
        ah = 0; al = 0; bh = 0; bl = 0; ch = 0; cl = 0; both = 0;
        for (int i = 0; i < 254; i++) begin
            @(negedge clk);
            ah += int'(bus.gate_AH);
            al += int'(bus.gate_AL);
            bh += int'(bus.gate_BH);
            bl += int'(bus.gate_BL);
            ch += int'(bus.gate_CH);
            cl += int'(bus.gate_CL);
            if ((bus.gate_AH && bus.gate_AL) || (bus.gate_BH && bus.gate_BL)
                || (bus.gate_CH && bus.gate_CL)) both++;
        end
    endtask

    task automatic enable_on(input string tag, input bit chk_resume);
        int hi = 0;
        enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            if (|gates()) hi++;
            if (i == 1) begin
                chk({tag, "_sync"}, 32'(bus.sync), 1);
                chk({tag, "_addr"}, 32'(bus.address), 0);
            end
        end
        chk({tag, "_gates_off"}, hi, 0);
        if (chk_resume) begin
            @(negedge clk);
            chk({tag, "_AH_resume"}, 32'(bus.gate_AH), 1);
        end
    endtask

    initial begin
        int sc, gc;
        bit found;
        rst_n = 1'b0;
        enable = 1'b0;
        freq_word = '0;
        bus.sine_A = 7'd64;
        bus.sine_B = 7'd0;
        bus.sine_C = 7'd100;

        #2;
        chk("rst_gates", 32'(gates()), 0);
        chk("rst_sync", 32'(bus.sync), 0);
        chk("rst_addr", 32'(bus.address), 0);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        freq_word = 24'h001000;
        @(negedge clk);
        enable_on("en0", 1'b0);

        expect_sync("step1", 1);
        expect_sync("step2", 2);
        @(posedge clk);
        #1 freq_word = 24'hFFC000;
        expect_sync("step3", 3);
        @(posedge clk);
        #1 freq_word = 24'h001000;
        expect_sync("wrap_top", SIN_SIZE - 1);
        expect_sync("wrap_zero", 0);
        expect_sync("wrap_one", 1);

        window();
        chk("duty_AH", ah, 119);
        chk("duty_AL", al, 119);
        chk("zero_BH", bh, 0);
        chk("zero_BL", bl, 254);
        chk("duty_CH", ch, 191);
        chk("duty_CL", cl, 47);
        chk("overlap", both, 0);

        repeat (100) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        chk("dis_gates", 32'(gates()), 0);
        chk("dis_addr", 32'(bus.address), 0);
        chk("dis_sync", 32'(bus.sync), 0);
        sc = 0;
        gc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            sc += int'(bus.sync);
            gc += int'(|gates());
        end
        chk("dis_sync_hold", sc, 0);
        chk("dis_gates_hold", gc, 0);
        enable_on("en1", 1'b1);

        bus.sine_A = 7'd3;
        repeat (600) @(negedge clk);
        window();
        chk("short_AH", ah, 0);
        chk("short_AL", al, 241);
        chk("short_overlap", both, 0);

        found = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (bus.gate_AL && bus.address != '0) begin
                found = 1;
                break;
            end
        end
        chk("midrst_ready", 32'(found), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_gates", 32'(gates()), 0);
        chk("midrst_sync", 32'(bus.sync), 0);
        chk("midrst_addr", 32'(bus.address), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("por_sync", 32'(bus.sync), 1);
        chk("por_addr0", 32'(bus.address), 0);
        chk("por_gates", 32'(gates()), 0);
        @(negedge clk);
        chk("por_addr1", 32'(bus.address), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
